// File: rtl/servo_ramp_sequencer_if.sv
// Command and servo-load signal bundle for servo_ramp_sequencer.
// Handshake: a command transfers on a rising CLOCK edge where CMD_VALID and
// CMD_READY are both high. While CMD_VALID is high and CMD_READY is low, the
// master holds CMD_CHANNEL/CMD_TARGET/CMD_STEP stable. CMD_READY does not
// depend on CMD_VALID.
interface servo_ramp_sequencer_if #(
  parameter int NO_OF_CHANNEL    = 4,
  parameter int ADDRESS_WIDTH    = (NO_OF_CHANNEL > 1) ? $clog2(NO_OF_CHANNEL) : 1,
  parameter int DUTY_CYCLE_WIDTH = 8
);
  logic                        CMD_VALID;
  logic                        CMD_READY;
  logic [ADDRESS_WIDTH-1:0]    CMD_CHANNEL;
  logic [DUTY_CYCLE_WIDTH-1:0] CMD_TARGET;
  logic [DUTY_CYCLE_WIDTH-1:0] CMD_STEP;
  logic                        LOAD_SIGNAL;
  logic [ADDRESS_WIDTH-1:0]    SERVO_SELECTOR;
  logic [DUTY_CYCLE_WIDTH-1:0] DUTY_CYCLE_CONTROL;
  logic [NO_OF_CHANNEL-1:0]    CHANNEL_SETTLED;
  logic                        BUSY;

  modport master (
    output CMD_VALID, CMD_CHANNEL, CMD_TARGET, CMD_STEP,
    input  CMD_READY, LOAD_SIGNAL, SERVO_SELECTOR, DUTY_CYCLE_CONTROL,
           CHANNEL_SETTLED, BUSY
  );

  modport slave (
    input  CMD_VALID, CMD_CHANNEL, CMD_TARGET, CMD_STEP,
    output CMD_READY, LOAD_SIGNAL, SERVO_SELECTOR, DUTY_CYCLE_CONTROL,
           CHANNEL_SETTLED, BUSY
  );
endinterface

// File: rtl/servo_ramp_sequencer.sv
// Servo ramp sequencer: on every update tick, walks all channels and moves
// each unsettled channel one bounded step toward its target, issuing a held
// LOAD_SIGNAL strobe to the downstream N-channel servo controller per step.
module servo_ramp_sequencer #(
  parameter int NO_OF_CHANNEL    = 4,
  parameter int ADDRESS_WIDTH    = (NO_OF_CHANNEL > 1) ? $clog2(NO_OF_CHANNEL) : 1,
  parameter int DUTY_CYCLE_WIDTH = 8,
  parameter int CLOCK_FREQUENCY  = 50000000,
  parameter int UPDATE_RATE      = 50,
  parameter int LOAD_HOLD_CYCLES = 4,
  parameter int RESET_DUTY       = 128
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  servo_ramp_sequencer_if.slave bus,
  output logic [1:0]            dbg_state
);

  localparam int AW          = ADDRESS_WIDTH;
  localparam int DW          = DUTY_CYCLE_WIDTH;
  localparam int TICK_PERIOD = (CLOCK_FREQUENCY / UPDATE_RATE > 0) ? CLOCK_FREQUENCY / UPDATE_RATE : 1;
  localparam int TCW         = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int HOLD        = (LOAD_HOLD_CYCLES < 1) ? 1 : LOAD_HOLD_CYCLES;
  localparam int HCW         = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [DW-1:0]  RST_DUTY  = DW'(RESET_DUTY);
  localparam logic [AW-1:0]  LAST_IDX  = AW'(NO_OF_CHANNEL - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_PERIOD - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_LOAD = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [TCW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [HCW-1:0]           hold_q, hold_d;
  logic                     pending_q, pending_d;
  logic [AW-1:0]            sel_q, sel_d;
  logic [DW-1:0]            duty_q, duty_d;
  logic [NO_OF_CHANNEL-1:0] settled_q, settled_d;
  logic [DW-1:0]            current_q [NO_OF_CHANNEL];
  logic [DW-1:0]            current_d [NO_OF_CHANNEL];
  logic [DW-1:0]            target_q  [NO_OF_CHANNEL];
  logic [DW-1:0]            target_d  [NO_OF_CHANNEL];
  logic [DW-1:0]            step_q    [NO_OF_CHANNEL];
  logic [DW-1:0]            step_d    [NO_OF_CHANNEL];

  logic          tick;
  logic          cmd_ready;
  logic          cmd_fire;
  logic          step_we;
  logic [DW-1:0] cur_sel, tgt_sel, stp_sel;
  logic [DW:0]   mag;
  logic          up;
  logic [DW-1:0] next_duty;

  // Free-running update-rate divider; tick is high on its terminal count.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Select the scanned channel's registers and compute its bounded step.
  // The distance is formed one bit wider so neither direction can wrap, and
  // a distance within one step lands exactly on the target.
  always_comb begin
    cur_sel = '0;
    tgt_sel = '0;
    stp_sel = '0;
    for (int i = 0; i < NO_OF_CHANNEL; i++) begin
      if (idx_q == AW'(i)) begin
        cur_sel = current_q[i];
        tgt_sel = target_q[i];
        stp_sel = step_q[i];
      end
    end
    up  = (tgt_sel > cur_sel);
    mag = up ? ({1'b0, tgt_sel} - {1'b0, cur_sel})
             : ({1'b0, cur_sel} - {1'b0, tgt_sel});
    if ((stp_sel == '0) || (mag <= {1'b0, stp_sel})) begin
      next_duty = tgt_sel;
    end else if (up) begin
      next_duty = cur_sel + stp_sel;
    end else begin
      next_duty = cur_sel - stp_sel;
    end
  end

  // Sequencer FSM next-state, command acceptance and channel register updates.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    duty_d    = duty_q;
    step_we   = 1'b0;

    cmd_ready = (state_q == ST_IDLE) && RESET;
    cmd_fire  = cmd_ready && bus.CMD_VALID;

    // Ticks that land mid-pass collapse into a single deferred pass.
    if (tick && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (cur_sel != tgt_sel) begin
          step_we = 1'b1;
          sel_d   = idx_q;
          duty_d  = next_duty;
          hold_d  = '0;
          state_d = ST_LOAD;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_LOAD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_GAP;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Out-of-range command channels match no entry and are dropped.
    for (int i = 0; i < NO_OF_CHANNEL; i++) begin
      current_d[i] = current_q[i];
      target_d[i]  = target_q[i];
      step_d[i]    = step_q[i];
      settled_d[i] = (current_q[i] == target_q[i]);
      if (cmd_fire && (bus.CMD_CHANNEL == AW'(i))) begin
        target_d[i] = bus.CMD_TARGET;
        step_d[i]   = bus.CMD_STEP;
      end
      if (step_we && (idx_q == AW'(i))) begin
        current_d[i] = next_duty;
      end
    end
  end

  // State and datapath registers, asynchronously reset to the rest position.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      pending_q  <= 1'b0;
      sel_q      <= '0;
      duty_q     <= RST_DUTY;
      settled_q  <= '1;
      for (int i = 0; i < NO_OF_CHANNEL; i++) begin
        current_q[i] <= RST_DUTY;
        target_q[i]  <= RST_DUTY;
        step_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      duty_q     <= duty_d;
      settled_q  <= settled_d;
      for (int i = 0; i < NO_OF_CHANNEL; i++) begin
        current_q[i] <= current_d[i];
        target_q[i]  <= target_d[i];
        step_q[i]    <= step_d[i];
      end
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  always_comb begin
    bus.CMD_READY          = cmd_ready;
    bus.LOAD_SIGNAL        = (state_q == ST_LOAD);
    bus.BUSY               = (state_q != ST_IDLE);
    bus.SERVO_SELECTOR     = sel_q;
    bus.DUTY_CYCLE_CONTROL = duty_q;
    bus.CHANNEL_SETTLED    = settled_q;
    dbg_state              = state_q;
  end

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Directed bench for servo_ramp_sequencer: expected load pulses are queued as
// stimulus is issued and a monitor pops/compares them on each LOAD rise.
module tb_servo_ramp_sequencer;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int W  = AW + DW;
  localparam int HOLD = 4;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  servo_ramp_sequencer_if #(
    .NO_OF_CHANNEL(N), .ADDRESS_WIDTH(AW), .DUTY_CYCLE_WIDTH(DW)
  ) bus ();

  servo_ramp_sequencer #(
    .NO_OF_CHANNEL(N), .ADDRESS_WIDTH(AW), .DUTY_CYCLE_WIDTH(DW),
    .CLOCK_FREQUENCY(1000), .UPDATE_RATE(100), .LOAD_HOLD_CYCLES(HOLD),
    .RESET_DUTY(128)
  ) dut (
    .CLOCK(clk), .RESET(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int ch, input int duty);
    return {AW'(ch), DW'(duty)};
  endfunction

  // ---------------- monitor ----------------
  logic          mon_prev  = 1'b0;
  logic          mon_gap   = 1'b0;
  int            mon_width = 0;
  logic [AW-1:0] mon_sel;
  logic [DW-1:0] mon_duty;
  logic [W-1:0]  mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev  = 1'b0;
        mon_gap   = 1'b0;
        mon_width = 0;
      end else begin
        if (mon_gap) begin
          check("gap_sel_stable", 32'(bus.SERVO_SELECTOR), 32'(mon_sel));
          check("gap_duty_stable", 32'(bus.DUTY_CYCLE_CONTROL), 32'(mon_duty));
          mon_gap = 1'b0;
        end
        if (bus.LOAD_SIGNAL) begin
          if (!mon_prev) begin
            mon_width = 1;
            mon_sel   = bus.SERVO_SELECTOR;
            mon_duty  = bus.DUTY_CYCLE_CONTROL;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_pulse: got ch %0d duty %0d, none expected", mon_sel, mon_duty);
            end else begin
              mon_exp = exp_q.pop_front();
              check("pulse_channel", 32'(mon_sel), 32'(mon_exp[W-1:DW]));
              check("pulse_duty", 32'(mon_duty), 32'(mon_exp[DW-1:0]));
            end
          end else begin
            mon_width++;
          end
        end else if (mon_prev) begin
          check("pulse_width", 32'(mon_width), 32'(HOLD));
          mon_gap = 1'b1;
        end
        mon_prev = bus.LOAD_SIGNAL;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int ch, input int tgt, input int stp);
    int waited = 0;
    @(negedge clk);
    bus.CMD_VALID   = 1'b1;
    bus.CMD_CHANNEL = AW'(ch);
    bus.CMD_TARGET  = DW'(tgt);
    bus.CMD_STEP    = DW'(stp);
    while (bus.CMD_READY !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept: got no CMD_READY in %0d cycles, required acceptance", waited);
    end
    @(posedge clk);
    #1;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_load_rise(input string name);
    int waited = 0;
    @(negedge clk);
    while (bus.LOAD_SIGNAL !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no LOAD_SIGNAL in %0d cycles, required a pulse", name, waited);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"}, 32'(bus.LOAD_SIGNAL), 32'(0));
    check({tag, "_busy"}, 32'(bus.BUSY), 32'(0));
    check({tag, "_ready"}, 32'(bus.CMD_READY), 32'(0));
    check({tag, "_sel"}, 32'(bus.SERVO_SELECTOR), 32'(0));
    check({tag, "_duty"}, 32'(bus.DUTY_CYCLE_CONTROL), 32'(128));
    check({tag, "_settled"}, 32'(bus.CHANNEL_SETTLED), 32'(4'b1111));
    check({tag, "_state"}, 32'(dbg_state), 32'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int low;
    int busy_low;
    int acc;
    int settled_bad;
    logic prev_busy;

    bus.CMD_VALID   = 1'b0;
    bus.CMD_CHANNEL = '0;
    bus.CMD_TARGET  = '0;
    bus.CMD_STEP    = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // First tick arrives ten cycles after release; an all-settled pass scans 4 channels.
    cnt = 0;
    while (bus.BUSY !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("first_tick_cycles", 32'(cnt), 32'(10));
    cnt = 0;
    while (bus.BUSY === 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("idle_pass_busy_cycles", 32'(cnt), 32'(4));

    // Ramp ch1 128 -> 140 in steps of 5.
    exp_q.push_back(pk(1, 133));
    exp_q.push_back(pk(1, 138));
    exp_q.push_back(pk(1, 140));
    send_cmd(1, 140, 5);
    @(negedge clk);
    @(negedge clk);
    check("ramp_settled_low", 32'(bus.CHANNEL_SETTLED), 32'(4'b1101));
    repeat (40) @(negedge clk);
    check("ramp_settled_high", 32'(bus.CHANNEL_SETTLED), 32'(4'b1111));
    check("ramp_queue_drained", 32'(exp_q.size()), 32'(0));

    // Large step downward clamps at 0 rather than wrapping.
    exp_q.push_back(pk(2, 0));
    send_cmd(2, 0, 200);
    repeat (25) @(negedge clk);
    check("nowrap_settled", 32'(bus.CHANNEL_SETTLED), 32'(4'b1111));
    check("nowrap_queue_drained", 32'(exp_q.size()), 32'(0));

    // Two jumps queued between ticks are served in one pass.
    cnt = 0;
    while (bus.BUSY !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (bus.BUSY === 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    exp_q.push_back(pk(0, 200));
    exp_q.push_back(pk(3, 10));
    send_cmd(0, 200, 0);
    send_cmd(3, 10, 0);
    wait_load_rise("pass_first_pulse");
    cnt = 0;
    while (bus.LOAD_SIGNAL === 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    low = 0;
    busy_low = 0;
    while (bus.LOAD_SIGNAL !== 1'b1 && low < 50) begin
      low++;
      if (bus.BUSY !== 1'b1) busy_low++;
      @(negedge clk);
    end
    check("pass_low_cycles_between", 32'(low), 32'(4));
    check("pass_busy_span", 32'(busy_low), 32'(0));
    repeat (20) @(negedge clk);
    check("pass_settled", 32'(bus.CHANNEL_SETTLED), 32'(4'b1111));
    check("pass_queue_drained", 32'(exp_q.size()), 32'(0));

    // Out-of-range channel is accepted and discarded.
    @(negedge clk);
    bus.CMD_VALID   = 1'b1;
    bus.CMD_CHANNEL = AW'(5);
    bus.CMD_TARGET  = DW'(77);
    bus.CMD_STEP    = DW'(0);
    acc = 0;
    settled_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.CMD_READY === 1'b1) acc++;
      if (bus.CHANNEL_SETTLED !== 4'b1111) settled_bad++;
    end
    bus.CMD_VALID = 1'b0;
    check("oob_accepted", 32'(acc > 0), 32'(1));
    check("oob_settled_stable", 32'(settled_bad), 32'(0));
    repeat (15) @(negedge clk);
    check("oob_queue_drained", 32'(exp_q.size()), 32'(0));

    // Command during LOAD waits for the first IDLE cycle.
    exp_q.push_back(pk(1, 150));
    send_cmd(1, 150, 0);
    wait_load_rise("busy_cmd_pulse");
    bus.CMD_VALID   = 1'b1;
    bus.CMD_CHANNEL = AW'(2);
    bus.CMD_TARGET  = DW'(5);
    bus.CMD_STEP    = DW'(0);
    check("ready_low_in_load", 32'(bus.CMD_READY), 32'(0));
    exp_q.push_back(pk(2, 5));
    prev_busy = 1'b1;
    cnt = 0;
    while (bus.CMD_READY !== 1'b1 && cnt < 100) begin
      prev_busy = bus.BUSY;
      @(negedge clk);
      cnt++;
    end
    check("accept_first_idle", 32'(prev_busy), 32'(1));
    check("accept_not_busy", 32'(bus.BUSY), 32'(0));
    @(posedge clk);
    #1;
    bus.CMD_VALID = 1'b0;
    repeat (25) @(negedge clk);
    check("busy_cmd_settled", 32'(bus.CHANNEL_SETTLED), 32'(4'b1111));
    check("busy_cmd_queue_drained", 32'(exp_q.size()), 32'(0));

    // Reset during a LOAD drops the strobe immediately and restores rest duty.
    exp_q.push_back(pk(1, 100));
    send_cmd(1, 100, 0);
    wait_load_rise("abort_pulse");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_load_async", 32'(bus.LOAD_SIGNAL), 32'(0));
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_settled", 32'(bus.CHANNEL_SETTLED), 32'(4'b1111));
    check("post_reset_queue_drained", 32'(exp_q.size()), 32'(0));

    // Ch1 restarts from 128 after reset.
    exp_q.push_back(pk(1, 129));
    exp_q.push_back(pk(1, 130));
    send_cmd(1, 130, 1);
    repeat (35) @(negedge clk);
    check("post_reset_ramp_settled", 32'(bus.CHANNEL_SETTLED), 32'(4'b1111));
    check("post_reset_ramp_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
